// File: rtl/run_seq_pkg.sv
// ----------------------------------------------------------------------------
// run_seq_pkg -- shared definitions for the run sequencer.
//   state_t        : sequencer FSM states
//   SEL_*          : prog_sel encodings (SEL_BAD is rejected in IDLE)
//   P*_BASE/P*_LEN : result region placement in data memory
//   region_t       : base and last address of a result region
//   region_lookup  : maps a latched prog_sel to its result region
// ----------------------------------------------------------------------------
package run_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_OUT
  } state_t;

  localparam logic [1:0] SEL_P0  = 2'd0;
  localparam logic [1:0] SEL_P1  = 2'd1;
  localparam logic [1:0] SEL_P2  = 2'd2;
  localparam logic [1:0] SEL_BAD = 2'd3;

  localparam logic [7:0] P0_BASE = 8'd64;
  localparam logic [7:0] P0_LEN  = 8'd2;
  localparam logic [7:0] P1_BASE = 8'd66;
  localparam logic [7:0] P1_LEN  = 8'd4;
  localparam logic [7:0] P2_BASE = 8'd64;
  localparam logic [7:0] P2_LEN  = 8'd64;

  typedef struct packed {
    logic [7:0] base;
    logic [7:0] last;
  } region_t;

  // SEL_BAD never gets latched, so it simply falls into the default arm.
  function automatic region_t region_lookup(input logic [1:0] sel);
    region_t r;
    case (sel)
      SEL_P1:  r = '{base: P1_BASE, last: P1_BASE + P1_LEN - 8'd1};
      SEL_P2:  r = '{base: P2_BASE, last: P2_BASE + P2_LEN - 8'd1};
      default: r = '{base: P0_BASE, last: P0_BASE + P0_LEN - 8'd1};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// ----------------------------------------------------------------------------
// run_sequencer_if -- bus bundle between the run sequencer and its
// environment: operand byte stream, data memory port, processor control and
// result byte stream.
//   master : the sequencer side (drives memory port, dut_start, results)
//   slave  : the environment side (operand source, memory, processor, sink)
// ----------------------------------------------------------------------------
interface run_sequencer_if;
  // operand byte stream
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  // data memory port; read data arrives one cycle after the address
  logic       mem_wr_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data;
  // processor control: dut_start high holds the processor, low lets it run
  logic       dut_start;
  logic       dut_done;
  // result byte stream
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    input  in_valid, in_data, mem_rd_data, dut_done, out_ready,
    output in_ready, mem_wr_en, mem_addr, mem_wr_data, dut_start,
           out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, mem_rd_data, dut_done, out_ready,
    input  in_ready, mem_wr_en, mem_addr, mem_wr_data, dut_start,
           out_valid, out_data
  );
endinterface

// File: rtl/run_sequencer.sv
// ----------------------------------------------------------------------------
// run_sequencer -- runs one program on an attached processor:
//   load LOAD_BYTES operand bytes into data memory 0.., release the processor,
//   wait for its done flag (with mask and timeout), then stream the selected
//   result region out of data memory one byte at a time.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   go        one-cycle run request, honoured only in IDLE
//   prog_sel  result region select, latched with go (3 = illegal -> error)
//   busy      high in every state except IDLE
//   error     sticky fault: illegal prog_sel or processor timeout
//   bus       run_sequencer_if.master (operand, memory, processor, results)
// ----------------------------------------------------------------------------
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int LOAD_BYTES     = 64,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int DONE_MASK      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [1:0] prog_sel,
  output logic       busy,
  output logic       error,
  run_sequencer_if.master bus
);

  localparam int               WAIT_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]       LOAD_LAST    = 8'(LOAD_BYTES - 1);
  localparam logic [WAIT_W-1:0] MASK_END    = WAIT_W'(DONE_MASK);
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t              state;
  logic [1:0]          sel_q;
  logic [7:0]          cnt;        // byte counter: load address, then read address
  logic [WAIT_W-1:0]   wait_cnt;   // WAIT cycles elapsed, 0 on the first WAIT cycle
  logic                in_ready_q;
  logic                out_valid_q;
  logic                dut_start_q;
  logic [7:0]          out_data_q;
  region_t             region;
  logic                in_fire;
  logic                out_fire;

  assign region   = region_lookup(sel_q);
  assign in_fire  = in_ready_q & bus.in_valid;
  assign out_fire = out_valid_q & bus.out_ready;

  // Handshake outputs are masked by reset so that a reset arriving mid-LOAD
  // or mid-OUT can neither write memory nor hand over a byte in that cycle.
  assign bus.in_ready    = in_ready_q & ~reset;
  assign bus.mem_wr_en   = in_fire & ~reset;
  assign bus.mem_addr    = cnt;
  assign bus.mem_wr_data = bus.in_data;
  assign bus.dut_start   = dut_start_q;
  assign bus.out_valid   = out_valid_q & ~reset;
  assign bus.out_data    = out_data_q;

  // NOTE: every register here is updated with non-blocking assignments so all
  // of them see the pre-edge values; blocking ones would make the result
  // depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      sel_q       <= SEL_P0;
      cnt         <= '0;
      wait_cnt    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      dut_start_q <= 1'b1;
      busy        <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            if (prog_sel == SEL_BAD) begin
              error <= 1'b1;
            end else begin
              sel_q      <= prog_sel;
              error      <= 1'b0;
              cnt        <= '0;
              in_ready_q <= 1'b1;
              busy       <= 1'b1;
              state      <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (in_fire) begin
            // The last byte leaves the counter where it is, so it can never
            // wrap even when LOAD_BYTES is 256.
            if (cnt == LOAD_LAST) begin
              in_ready_q  <= 1'b0;
              dut_start_q <= 1'b0;
              state       <= S_LAUNCH;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end

        S_LAUNCH: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          // A done accepted on the final WAIT cycle beats the timeout.
          if (bus.dut_done && (wait_cnt >= MASK_END)) begin
            dut_start_q <= 1'b1;
            cnt         <= region.base;
            state       <= S_RD_REQ;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            error       <= 1'b1;
            dut_start_q <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_RD_REQ: begin
          state <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          out_data_q  <= bus.mem_rd_data;
          out_valid_q <= 1'b1;
          state       <= S_OUT;
        end

        S_OUT: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            if (cnt == region.last) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              cnt   <= cnt + 8'd1;
              state <= S_RD_REQ;
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// ----------------------------------------------------------------------------
// tb_run_sequencer -- directed bench for run_sequencer. Models a 256-byte
// data memory with one-cycle read latency and drives the processor done flag
// by hand. Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_run_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic [1:0] prog_sel;
  logic       busy;
  logic       error;

  run_sequencer_if bus ();

  run_sequencer #(
    .LOAD_BYTES    (64),
    .TIMEOUT_CYCLES(100),
    .DONE_MASK     (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .go      (go),
    .prog_sel(prog_sel),
    .busy    (busy),
    .error   (error),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- memory model and monitors ----------------
  logic [7:0] mem [256];
  int         cyc = 0;
  int         wr_addr_q[$];
  int         wr_data_q[$];
  int         wr_cyc_q[$];
  int         outv_seen = 0;
  logic [7:0] got_q[$];
  int         stalls;

  always @(posedge clk) begin
    cyc++;
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr] = bus.mem_wr_data;
      wr_addr_q.push_back(int'(bus.mem_addr));
      wr_data_q.push_back(int'(bus.mem_wr_data));
      wr_cyc_q.push_back(cyc);
    end
    bus.mem_rd_data <= mem[bus.mem_addr];
    if (bus.out_valid) outv_seen++;
  end

  function automatic logic [7:0] data_of(input int i);
    return 8'(i * 7 + 17);
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic start(input logic [1:0] sel);
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    @(negedge clk);
    go       = 1'b1;
    prog_sel = sel;
    @(negedge clk);
    go       = 1'b0;
    prog_sel = 2'd0;
  endtask

  // Streams n operand bytes; returns at the falling edge after the last accept.
  task automatic load(input bit gap, input int n, output int accepted);
    accepted = 0;
    for (int c = 0; c < 600 && accepted < n; c++) begin
      bus.in_valid = gap ? (c % 2 == 0) : 1'b1;
      bus.in_data  = data_of(accepted);
      if (bus.in_valid && bus.in_ready) accepted++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input bit consecutive, input int n);
    int bad_a = 0, bad_d = 0, bad_c = 0;
    check({tag, "_wr_count"}, wr_addr_q.size(), n);
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] != i) bad_a++;
      if (wr_data_q[i] != int'(data_of(i))) bad_d++;
      if (consecutive && i > 0 && wr_cyc_q[i] != wr_cyc_q[i-1] + 1) bad_c++;
    end
    check({tag, "_wr_addr_bad"}, bad_a, 0);
    check({tag, "_wr_data_bad"}, bad_d, 0);
    if (consecutive) check({tag, "_wr_gap_bad"}, bad_c, 0);
  endtask

  // Starts at the LAUNCH falling edge; raises dut_done after `delay` falling
  // edges (never if negative), optionally pulses go at go_at, and returns the
  // number of falling edges until dut_start is seen high again.
  task automatic wait_done(input int delay, input int go_at, output int lat);
    lat = 0;
    while (bus.dut_start !== 1'b1 && lat < 300) begin
      if (lat == delay) bus.dut_done = 1'b1;
      go       = (lat == go_at);
      prog_sel = (lat == go_at) ? 2'd1 : 2'd0;
      @(negedge clk);
      lat++;
    end
    go           = 1'b0;
    prog_sel     = 2'd0;
    bus.dut_done = 1'b0;
  endtask

  // Collects n result bytes into got_q, stalling 3 cycles on byte stall_idx.
  task automatic read_out(input string tag, input int n, input int stall_idx);
    logic [7:0] held;
    got_q.delete();
    stalls = 0;
    held   = '0;
    for (int c = 0; c < 1000 && got_q.size() < n; c++) begin
      if (bus.out_valid) begin
        if (got_q.size() == stall_idx && stalls < 3) begin
          if (stalls == 0) held = bus.out_data;
          else check({tag, "_stall_stable"}, bus.out_data, held);
          bus.out_ready = 1'b0;
          stalls++;
        end else begin
          if (got_q.size() == stall_idx) check({tag, "_stall_release"}, bus.out_data, held);
          bus.out_ready = 1'b1;
          got_q.push_back(bus.out_data);
        end
      end else begin
        bus.out_ready = 1'b0;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    check({tag, "_rd_count"}, got_q.size(), n);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_out_valid"}, bus.out_valid, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int acc, lat, bad, ov0;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset         = 1'b1;
    go            = 1'b0;
    prog_sel      = 2'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.dut_done  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_in_ready",  bus.in_ready,  1'b0);
    check("rst_mem_wr_en", bus.mem_wr_en, 1'b0);
    check("rst_dut_start", bus.dut_start, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data",  bus.out_data,  8'h00);
    check("rst_busy",      busy,          1'b0);
    check("rst_error",     error,         1'b0);
    check("rst_counter",   bus.mem_addr,  8'h00);
    reset = 1'b0;

    // A: prog_sel 0, full-rate load, go ignored while busy
    mem[64] = 8'h03;
    mem[65] = 8'h0B;
    start(2'd0);
    check("a_busy",      busy,          1'b1);
    check("a_in_ready",  bus.in_ready,  1'b1);
    check("a_start_hold", bus.dut_start, 1'b1);
    load(1'b0, 64, acc);
    check_writes("a", 1'b1, 64);
    check("a_launch_start", bus.dut_start, 1'b0);
    check("a_launch_ready", bus.in_ready,  1'b0);
    check("a_launch_wr",    bus.mem_wr_en, 1'b0);
    wait_done(8, 3, lat);
    check("a_done_lat", lat, 9);
    read_out("a", 2, -1);
    check("a_byte0", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h03);
    check("a_byte1", got_q.size() > 1 ? got_q[1] : 8'hxx, 8'h0B);

    // B: prog_sel 1, in_valid every other cycle, done held from launch
    for (int k = 0; k < 4; k++) mem[66 + k] = 8'(8'hC0 + k);
    start(2'd1);
    load(1'b1, 64, acc);
    check_writes("b", 1'b0, 64);
    wait_done(0, -1, lat);
    check("b_mask_lat", lat, 6);
    read_out("b", 4, -1);
    bad = 0;
    for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== 8'(8'hC0 + k)) bad++;
    check("b_data_bad", bad, 0);

    // C: prog_sel 2, 64-byte readout with a 3-cycle stall on byte 10
    for (int k = 0; k < 64; k++) mem[64 + k] = 8'(k * 5 + 9);
    start(2'd2);
    load(1'b0, 64, acc);
    check("c_loaded", acc, 64);
    wait_done(8, -1, lat);
    check("c_done_lat", lat, 9);
    read_out("c", 64, 10);
    check("c_stalls", stalls, 3);
    bad = 0;
    for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== 8'(k * 5 + 9)) bad++;
    check("c_data_bad", bad, 0);

    // D: processor never finishes -> timeout after 100 WAIT cycles
    start(2'd0);
    load(1'b0, 64, acc);
    ov0 = outv_seen;
    wait_done(-1, -1, lat);
    check("d_timeout_lat", lat, 101);
    check("d_error",       error,         1'b1);
    check("d_start",       bus.dut_start, 1'b1);
    check("d_busy",        busy,          1'b0);
    repeat (4) @(negedge clk);
    check("d_no_out", outv_seen - ov0, 0);

    // E: new go clears error; reset lands on load byte 30
    start(2'd0);
    check("e_error_clr", error, 1'b0);
    load(1'b0, 30, acc);
    bus.in_valid = 1'b1;
    bus.in_data  = data_of(30);
    reset        = 1'b1;
    @(negedge clk);
    check("e_rst_in_ready",  bus.in_ready,  1'b0);
    check("e_rst_dut_start", bus.dut_start, 1'b1);
    check("e_rst_busy",      busy,          1'b0);
    check("e_rst_out_valid", bus.out_valid, 1'b0);
    check("e_rst_counter",   bus.mem_addr,  8'h00);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check_writes("e", 1'b1, 30);

    // Illegal prog_sel sets error and stays idle
    start(2'd3);
    check("e_bad_sel_err",  error, 1'b1);
    check("e_bad_sel_busy", busy,  1'b0);

    // F: fresh run reloads from address 0
    mem[64] = 8'h5A;
    mem[65] = 8'hA5;
    start(2'd0);
    check("f_error_clr", error, 1'b0);
    load(1'b0, 64, acc);
    check_writes("f", 1'b1, 64);
    wait_done(5, -1, lat);
    check("f_done_lat", lat, 6);
    read_out("f", 2, -1);
    check("f_byte0", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h5A);
    check("f_byte1", got_q.size() > 1 ? got_q[1] : 8'hxx, 8'hA5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter LOAD_BYTES, default 64: operand bytes written to data memory at addresses 0..LOAD_BYTES-1 per run.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum WAIT cycles before the run is aborted.
REQ-003 Parameter DONE_MASK, default 4: WAIT cycles after launch during which dut_done is ignored.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- go  in  1  one-cycle run request; sampled only in IDLE.
- prog_sel  in  2  result region select, latched with go.
- in_valid / in_ready  in / out  1 / 1  operand byte handshake.
- in_data  in  8  operand byte.
- mem_wr_en  out  1  data memory write strobe.
- mem_addr  out  8  data memory address (write and read).
- mem_wr_data  out  8  data memory write byte.
- mem_rd_data  in  8  data memory read byte, valid one cycle after mem_addr is presented.
- dut_start  out  1  processor start: high = hold, low = run.
- dut_done  in  1  processor completion flag.
- out_valid / out_ready  out / in  1 / 1  result byte handshake.
- out_data  out  8  result byte.
- busy  out  1  high in every state except IDLE.
- error  out  1  sticky fault flag.

Function
REQ-005 States SHALL be IDLE, LOAD, LAUNCH, WAIT, RD_REQ, RD_WAIT, OUT.
REQ-006 IDLE: go=1 SHALL latch prog_sel, clear error and the byte counter, and enter LOAD; prog_sel=3 SHALL instead set error and stay in IDLE.
REQ-007 LOAD: in_ready=1; each in_valid&in_ready cycle SHALL drive mem_wr_en=1, mem_addr=counter, mem_wr_data=in_data combinationally, then increment the counter.
REQ-008 When the LOAD_BYTES-th byte is accepted, the FSM SHALL enter LAUNCH the next cycle; in_ready SHALL be 0 outside LOAD.
REQ-009 LAUNCH (1 cycle): dut_start SHALL go low and remain low through WAIT; the cycle counter SHALL clear.
REQ-010 WAIT: dut_done SHALL be ignored for the first DONE_MASK cycles; afterwards dut_done=1 SHALL raise dut_start and enter RD_REQ with the counter at the region base.
REQ-011 If WAIT lasts TIMEOUT_CYCLES cycles without an accepted done, the FSM SHALL set error, raise dut_start and return to IDLE with no readout.
REQ-012 Result regions: prog_sel 0 -> base 64, length 2; 1 -> base 66, length 4; 2 -> base 64, length 64.
REQ-013 RD_REQ SHALL drive mem_addr=counter; RD_WAIT SHALL capture mem_rd_data into out_data; OUT SHALL hold out_valid=1 and out_data stable until out_ready.
REQ-014 On out_valid&out_ready, the FSM SHALL return to RD_REQ with counter+1, or to IDLE after the last region byte.
REQ-015 go SHALL be ignored while busy; mem_wr_en SHALL be 0 outside LOAD; the counter SHALL never wrap past 255.

Reset
REQ-016 Reset SHALL force IDLE, and on the next edge in_ready=0, mem_wr_en=0, dut_start=1, out_valid=0, out_data=0, busy=0, error=0, with both counters at 0.
REQ-017 Reset in any state, including mid-LOAD and mid-WAIT, SHALL abort the run with no further memory writes or output bytes.
REQ-018 Reset SHALL take priority over go, dut_done and all handshakes in the same cycle.

Structure
REQ-019 The state enum, region base/length constants and prog_sel encodings SHALL live in a shared package, run_seq_pkg.
REQ-020 The block SHALL be one module; the region lookup SHALL be a package function, not a sub-module.

Verification
REQ-021 Load plus prog_sel=0: 64 bytes streamed at full rate -> 64 writes to addresses 0..63 in consecutive cycles, dut_start low; model done with mem[64]=0x03, mem[65]=0x0B -> out bytes 0x03, 0x0B, then IDLE.
REQ-022 in_valid toggled every other cycle -> exactly 64 writes, no duplicates, addresses contiguous.
REQ-023 dut_done held high from launch -> ignored for 4 cycles, accepted on WAIT cycle 5, dut_start high the next cycle.
REQ-024 dut_done never asserted, TIMEOUT_CYCLES=100 -> error=1 after 100 WAIT cycles, dut_start=1, no out_valid.
REQ-025 prog_sel=2 with out_ready low for 3 cycles on byte 10 -> out_data stable while stalled, 64 bytes from addresses 64..127 in order.
REQ-026 Reset asserted on load byte 30 -> outputs at reset values next edge; a new go reloads from address 0.
